// File: rtl/spi_process_param_pkg.sv
// Shared types for the parametrised SPI message processor.
// RX framing and TX serialiser state encodings.
package spi_process_param_pkg;

  typedef enum logic {
    FRM_HDR,
    FRM_PAY
  } frm_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_state_t;

  localparam int SYNC_DEF = 2;

endpackage

// File: rtl/spi_process_param_fifo.sv
// Word FIFO with registered read data.
// Reports free words and a write-dropped strobe.
module spi_process_param_fifo #(
  parameter int W  = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  q,
  output logic [AW:0]   free,
  output logic          ovf
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [AW:0]  used;
  logic         empty;
  logic         full;
  logic         rd_ok;
  logic         wr_ok;

  assign used  = wptr - rptr;
  assign empty = (used == '0);
  assign full  = (used == (AW+1)'(DEPTH));
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);
  assign ovf   = wr_en & ~wr_ok;
  assign free  = (AW+1)'(DEPTH) - used;

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= wr_data;
  end

  // pointers and registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      q    <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
        q    <= mem[rptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/spi_process_param.sv
// SPI message processor: RX deserialiser, framed FIFO,
// TX serialiser with divider and far-end pause.
module spi_process_param
  import spi_process_param_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int FIFO_AW     = 8,
  parameter int LEN_W       = 8,
  parameter int AFULL_GAP   = 4,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int TX_DIV      = 4
) (
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              RX_CLK,
  input  logic              RX_DATA,
  input  logic              RX_LOAD,
  input  logic              RX_STOP,
  input  logic              SWAP_EN,
  input  logic              RD_REQ,
  input  logic              MSG_START,
  output logic [WORD_W-1:0] FIFO_Q,
  output logic              GOT_FULL_MSG,
  output logic [LEN_W-1:0]  MSG_LEN,
  output logic              RX_OVF,
  output logic              RX_FRM_ERR,
  output logic              TX_CLK_O,
  output logic              TX_DATA,
  output logic              TX_LOAD,
  output logic              TX_STOP,
  input  logic [WORD_W-1:0] DATA,
  input  logic              ENA,
  output logic              TX_BUSY
);
  localparam int CW  = $clog2(WORD_W + 1);
  localparam int DW  = $clog2(2 * TX_DIV) + 1;
  localparam int MCW = FIFO_AW + 1;

  logic [SYNC_STAGES-1:0] s_clk, s_dat, s_load, s_stop;
  logic clk_s, dat_s, load_s, stop_s, clk_q;
  logic [WORD_W-2:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              wr_vld;
  logic [WORD_W-1:0] wr_word;

  frm_state_t       frm;
  logic [LEN_W-1:0] rem;
  logic             msg_done;
  logic [MCW-1:0]   msg_cnt, msg_cnt_nxt;
  logic             pop_hdr, rd_en, hdr_pend, ovf;
  logic [LEN_W-1:0] msg_len_q;
  logic [WORD_W-1:0] q, q_sw;
  logic [FIFO_AW:0] free;

  tx_state_t         tx_st;
  logic [DW-1:0]     div;
  logic [CW-1:0]     tx_bit;
  logic [WORD_W-1:0] tx_sh;

  assign clk_s  = s_clk[SYNC_STAGES-1];
  assign dat_s  = s_dat[SYNC_STAGES-1];
  assign load_s = s_load[SYNC_STAGES-1];
  assign stop_s = s_stop[SYNC_STAGES-1];

  // synchronise the far-end serial inputs
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      s_clk  <= '0;
      s_dat  <= '0;
      s_load <= '0;
      s_stop <= '0;
    end else begin
      s_clk  <= (s_clk << 1)  | SYNC_STAGES'(RX_CLK);
      s_dat  <= (s_dat << 1)  | SYNC_STAGES'(RX_DATA);
      s_load <= (s_load << 1) | SYNC_STAGES'(RX_LOAD);
      s_stop <= (s_stop << 1) | SYNC_STAGES'(RX_STOP);
    end
  end

  // deserialise on RX clock rising edge, catch short frames
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      clk_q      <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      wr_vld     <= 1'b0;
      wr_word    <= '0;
      RX_FRM_ERR <= 1'b0;
    end else begin
      clk_q      <= clk_s;
      wr_vld     <= 1'b0;
      RX_FRM_ERR <= 1'b0;
      if (!load_s) begin
        bit_cnt <= '0;
        if (bit_cnt != '0) RX_FRM_ERR <= 1'b1;
      end else if (clk_s && !clk_q) begin
        shreg <= {shreg[WORD_W-3:0], dat_s};
        if (bit_cnt == CW'(WORD_W - 1)) begin
          bit_cnt <= '0;
          wr_vld  <= 1'b1;
          wr_word <= {shreg, dat_s};
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  assign pop_hdr = MSG_START & GOT_FULL_MSG;
  assign rd_en   = pop_hdr | (RD_REQ & ~MSG_START);

  // message boundary detection and count update
  always_comb begin
    msg_done    = 1'b0;
    msg_cnt_nxt = msg_cnt;
    if (wr_vld) begin
      if (frm == FRM_HDR) msg_done = (wr_word[LEN_W-1:0] == '0);
      else                msg_done = (rem == LEN_W'(1));
    end
    if (msg_done && !pop_hdr)      msg_cnt_nxt = msg_cnt + 1'b1;
    else if (!msg_done && pop_hdr) msg_cnt_nxt = msg_cnt - 1'b1;
  end

  // framing state, message count and status flags
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      frm          <= FRM_HDR;
      rem          <= '0;
      msg_cnt      <= '0;
      GOT_FULL_MSG <= 1'b0;
      RX_OVF       <= 1'b0;
      TX_STOP      <= 1'b0;
      hdr_pend     <= 1'b0;
      msg_len_q    <= '0;
    end else begin
      if (wr_vld) begin
        if (frm == FRM_HDR) begin
          if (wr_word[LEN_W-1:0] != '0) begin
            frm <= FRM_PAY;
            rem <= wr_word[LEN_W-1:0];
          end
        end else begin
          rem <= rem - 1'b1;
          if (rem == LEN_W'(1)) frm <= FRM_HDR;
        end
      end
      msg_cnt      <= msg_cnt_nxt;
      GOT_FULL_MSG <= (msg_cnt_nxt != '0);
      if (ovf) RX_OVF <= 1'b1;
      TX_STOP  <= (free < (FIFO_AW+1)'(AFULL_GAP));
      hdr_pend <= pop_hdr;
      if (hdr_pend) msg_len_q <= q[LEN_W-1:0];
    end
  end

  spi_process_param_fifo #(
    .W  (WORD_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (SYS_CLK),
    .rst_n   (RST),
    .wr_en   (wr_vld),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .q       (q),
    .free    (free),
    .ovf     (ovf)
  );

  // byte-reverse the read word
  always_comb begin
    q_sw = q;
    for (int i = 0; i < WORD_W / 8; i++)
      q_sw[8*i +: 8] = q[WORD_W-8-8*i +: 8];
  end

  assign FIFO_Q  = SWAP_EN ? q_sw : q;
  assign MSG_LEN = hdr_pend ? q[LEN_W-1:0] : msg_len_q;

  // TX serialiser: pause only while the bit clock is low
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      tx_st    <= TX_IDLE;
      div      <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      TX_CLK_O <= 1'b0;
      TX_DATA  <= 1'b0;
      TX_LOAD  <= 1'b0;
      TX_BUSY  <= 1'b0;
    end else begin
      case (tx_st)
        TX_IDLE: begin
          if (ENA) begin
            tx_st    <= TX_SHIFT;
            tx_sh    <= DATA;
            TX_DATA  <= DATA[WORD_W-1];
            TX_LOAD  <= 1'b1;
            TX_BUSY  <= 1'b1;
            TX_CLK_O <= 1'b0;
            div      <= '0;
            tx_bit   <= '0;
          end
        end
        TX_SHIFT: begin
          if (!stop_s || TX_CLK_O) begin
            if (div == DW'(TX_DIV - 1)) begin
              div      <= '0;
              TX_CLK_O <= ~TX_CLK_O;
              if (TX_CLK_O) begin
                if (tx_bit == CW'(WORD_W - 1)) begin
                  tx_st   <= TX_GAP;
                  TX_LOAD <= 1'b0;
                  TX_DATA <= 1'b0;
                end else begin
                  tx_bit  <= tx_bit + 1'b1;
                  tx_sh   <= tx_sh << 1;
                  TX_DATA <= tx_sh[WORD_W-2];
                end
              end
            end else begin
              div <= div + 1'b1;
            end
          end
        end
        TX_GAP: begin
          if (div == DW'(2 * TX_DIV - 1)) begin
            div     <= '0;
            tx_st   <= TX_IDLE;
            TX_BUSY <= 1'b0;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_process_param.sv
// Directed and randomised bench for spi_process_param.
// Queue-based message model, serial TX capture.
module tb_spi_process_param;

  logic        SYS_CLK = 1'b0;
  logic        RST, RX_CLK, RX_DATA, RX_LOAD, RX_STOP;
  logic        SWAP_EN, RD_REQ, MSG_START, ENA;
  logic [15:0] DATA, FIFO_Q;
  logic        GOT_FULL_MSG, RX_OVF, RX_FRM_ERR;
  logic [7:0]  MSG_LEN;
  logic        TX_CLK_O, TX_DATA, TX_LOAD, TX_STOP, TX_BUSY;

  int tests = 0;
  int fails = 0;
  int frm_cnt = 0;

  logic [15:0] mq[$];
  int          m_msgs = 0;
  bit          m_pay = 0;
  int          m_rem = 0;
  bit          m_ovf = 0;

  bit  tx_bits[$];
  time tx_rise[$];

  spi_process_param #(
    .WORD_W(16), .FIFO_AW(8), .LEN_W(8),
    .AFULL_GAP(4), .SYNC_STAGES(2), .TX_DIV(4)
  ) dut (
    .SYS_CLK(SYS_CLK), .RST(RST),
    .RX_CLK(RX_CLK), .RX_DATA(RX_DATA),
    .RX_LOAD(RX_LOAD), .RX_STOP(RX_STOP),
    .SWAP_EN(SWAP_EN), .RD_REQ(RD_REQ),
    .MSG_START(MSG_START), .FIFO_Q(FIFO_Q),
    .GOT_FULL_MSG(GOT_FULL_MSG), .MSG_LEN(MSG_LEN),
    .RX_OVF(RX_OVF), .RX_FRM_ERR(RX_FRM_ERR),
    .TX_CLK_O(TX_CLK_O), .TX_DATA(TX_DATA),
    .TX_LOAD(TX_LOAD), .TX_STOP(TX_STOP),
    .DATA(DATA), .ENA(ENA), .TX_BUSY(TX_BUSY)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  always @(negedge SYS_CLK)
    if (RX_FRM_ERR === 1'b1) frm_cnt++;

  always @(posedge TX_CLK_O)
    if (TX_LOAD === 1'b1) begin
      tx_bits.push_back(TX_DATA);
      tx_rise.push_back($time);
    end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sw(input logic [15:0] w);
    return SWAP_EN ? {w[7:0], w[15:8]} : w;
  endfunction

  task automatic model_write(input logic [15:0] w);
    if (mq.size() < 256) mq.push_back(w);
    else m_ovf = 1;
    if (!m_pay) begin
      if (w[7:0] == 8'd0) m_msgs++;
      else begin
        m_pay = 1;
        m_rem = int'(w[7:0]);
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_pay = 0;
        m_msgs++;
      end
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_msgs = 0;
    m_pay = 0;
    m_rem = 0;
    m_ovf = 0;
  endtask

  task automatic rx_bits(input logic [15:0] w, input int n,
                         input bit drop);
    RX_LOAD = 1'b1;
    for (int i = 0; i < n; i++) begin
      RX_DATA = w[15-i];
      repeat (2) @(negedge SYS_CLK);
      RX_CLK = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      RX_CLK = 1'b0;
    end
    if (drop) begin
      repeat (2) @(negedge SYS_CLK);
      RX_LOAD = 1'b0;
      repeat (2) @(negedge SYS_CLK);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    rx_bits(w, 16, 1'b1);
    model_write(w);
    repeat (4) @(negedge SYS_CLK);
  endtask

  task automatic pop_hdr_chk();
    logic [15:0] e;
    MSG_START = 1'b1;
    @(negedge SYS_CLK);
    MSG_START = 1'b0;
    e = mq.pop_front();
    m_msgs--;
    chk("hdr_q", 32'(FIFO_Q), 32'(sw(e)));
    chk("msg_len", 32'(MSG_LEN), 32'(e[7:0]));
    chk("got_full_after_hdr", 32'(GOT_FULL_MSG),
        32'(m_msgs != 0));
  endtask

  task automatic rd_chk();
    logic [15:0] e;
    RD_REQ = 1'b1;
    @(negedge SYS_CLK);
    RD_REQ = 1'b0;
    e = mq.pop_front();
    chk("rd_q", 32'(FIFO_Q), 32'(sw(e)));
  endtask

  task automatic wait_tx_idle(input string tag);
    int n = 0;
    while (TX_BUSY === 1'b1 && n < 600) begin
      @(negedge SYS_CLK);
      n++;
    end
    chk(tag, 32'(n < 600), 32'd1);
  endtask

  task automatic tx_word_chk(input string tag,
                             input logic [15:0] e);
    logic [15:0] w = '0;
    for (int i = 0; i < tx_bits.size(); i++)
      w = {w[14:0], tx_bits[i]};
    chk({tag, "_nbits"}, 32'(tx_bits.size()), 32'd16);
    chk({tag, "_word"}, 32'(w), 32'(e));
  endtask

  initial begin
    logic [15:0] hdr, w, prev;
    int n0, len;

    RST = 1'b0; RX_CLK = 0; RX_DATA = 0; RX_LOAD = 0;
    RX_STOP = 0; SWAP_EN = 0; RD_REQ = 0; MSG_START = 0;
    ENA = 0; DATA = '0;
    repeat (3) @(negedge SYS_CLK);
    chk("reset_outs", {FIFO_Q, GOT_FULL_MSG, MSG_LEN, RX_OVF,
        RX_FRM_ERR, TX_CLK_O, TX_DATA, TX_LOAD, TX_STOP,
        TX_BUSY}, 32'd0);
    RST = 1'b1;
    repeat (3) @(negedge SYS_CLK);

    // 1: plain message, early MSG_START ignored
    send_word(16'h0003);
    send_word(16'hA1B2);
    chk("got_full_partial", 32'(GOT_FULL_MSG), 32'd0);
    MSG_START = 1'b1;
    @(negedge SYS_CLK);
    MSG_START = 1'b0;
    chk("msg_len_ignored", 32'(MSG_LEN), 32'd0);
    send_word(16'hC3D4);
    send_word(16'hE5F6);
    chk("got_full_msg", 32'(GOT_FULL_MSG), 32'd1);
    pop_hdr_chk();
    repeat (3) rd_chk();

    // 2: same message byte-swapped
    SWAP_EN = 1'b1;
    send_word(16'h0003);
    send_word(16'hA1B2);
    send_word(16'hC3D4);
    send_word(16'hE5F6);
    chk("got_full_msg_sw", 32'(GOT_FULL_MSG), 32'd1);
    pop_hdr_chk();
    repeat (3) rd_chk();
    SWAP_EN = 1'b0;

    // 3: zero-length message and short frame
    send_word(16'h0000);
    chk("got_full_zero", 32'(GOT_FULL_MSG), 32'd1);
    pop_hdr_chk();
    n0 = frm_cnt;
    rx_bits(16'hFFFF, 9, 1'b1);
    repeat (6) @(negedge SYS_CLK);
    chk("frm_err_pulse", 32'(frm_cnt - n0), 32'd1);
    chk("frm_no_msg", 32'(GOT_FULL_MSG), 32'd0);
    prev = FIFO_Q;
    RD_REQ = 1'b1;
    @(negedge SYS_CLK);
    RD_REQ = 1'b0;
    chk("rd_empty_hold", 32'(FIFO_Q), 32'(prev));
    send_word(16'h1200);
    chk("frm_then_ok", 32'(GOT_FULL_MSG), 32'd1);
    pop_hdr_chk();

    // random messages
    for (int m = 0; m < 4; m++) begin
      SWAP_EN = 1'($urandom);
      len = int'($urandom_range(0, 3));
      hdr = {8'($urandom_range(0, 255)), 8'(len)};
      send_word(hdr);
      for (int k = 0; k < len; k++) send_word(16'($urandom));
      chk("rand_got_full", 32'(GOT_FULL_MSG), 32'd1);
      pop_hdr_chk();
      for (int k = 0; k < len; k++) rd_chk();
    end
    SWAP_EN = 1'b0;

    // 5: TX with pause and ignored ENA
    tx_bits.delete();
    tx_rise.delete();
    DATA = 16'h8001;
    ENA = 1'b1;
    @(negedge SYS_CLK);
    ENA = 1'b0;
    chk("tx_busy_start", 32'({TX_BUSY, TX_LOAD}), 32'd3);
    repeat (20) @(negedge SYS_CLK);
    DATA = 16'hFFFF;
    ENA = 1'b1;
    @(negedge SYS_CLK);
    ENA = 1'b0;
    repeat (30) @(negedge SYS_CLK);
    RX_STOP = 1'b1;
    repeat (12) @(negedge SYS_CLK);
    n0 = tx_bits.size();
    chk("tx_pause_clk_low", 32'(TX_CLK_O), 32'd0);
    repeat (40) @(negedge SYS_CLK);
    chk("tx_pause_hold", 32'(tx_bits.size()), 32'(n0));
    chk("tx_pause_busy", 32'(TX_BUSY), 32'd1);
    RX_STOP = 1'b0;
    wait_tx_idle("tx_done_timeout");
    tx_word_chk("tx_8001", 16'h8001);
    chk("tx_bit_period", tx_rise.size() >= 2 ?
        32'(tx_rise[1] - tx_rise[0]) : 32'd0, 32'd80);
    repeat (20) @(negedge SYS_CLK);
    chk("tx_ena_ignored", 32'(TX_BUSY), 32'd0);

    tx_bits.delete();
    tx_rise.delete();
    w = 16'($urandom);
    DATA = w;
    ENA = 1'b1;
    @(negedge SYS_CLK);
    ENA = 1'b0;
    wait_tx_idle("tx_rand_timeout");
    tx_word_chk("tx_rand", w);

    // 4: fill FIFO, back-pressure and overflow
    for (int k = 1; k <= 257; k++) begin
      if (k == 1)        w = 16'h00FF;
      else if (k == 257) w = 16'h0005;
      else               w = 16'(k);
      send_word(w);
      if (k == 252 || k == 253 || k == 256)
        chk("tx_stop_level", 32'(TX_STOP),
            32'((256 - mq.size()) < 4));
      if (k == 256)
        chk("ovf_before", 32'(RX_OVF), 32'(m_ovf));
      if (k == 257)
        chk("ovf_after", 32'(RX_OVF), 32'(m_ovf));
    end
    chk("full_got_msg", 32'(GOT_FULL_MSG), 32'(m_msgs != 0));

    // 6: async reset mid RX and TX
    DATA = 16'h1234;
    ENA = 1'b1;
    @(negedge SYS_CLK);
    ENA = 1'b0;
    rx_bits(16'hBEEF, 5, 1'b0);
    chk("ovf_sticky", 32'(RX_OVF), 32'd1);
    chk("tx_mid_busy", 32'(TX_BUSY), 32'd1);
    #2 RST = 1'b0;
    #1 chk("async_reset_outs", {FIFO_Q, GOT_FULL_MSG, MSG_LEN,
        RX_OVF, RX_FRM_ERR, TX_CLK_O, TX_DATA, TX_LOAD, TX_STOP,
        TX_BUSY}, 32'd0);
    RX_LOAD = 1'b0;
    RX_CLK = 1'b0;
    model_reset();
    @(negedge SYS_CLK);
    @(negedge SYS_CLK);
    RST = 1'b1;
    repeat (4) @(negedge SYS_CLK);
    send_word(16'h0102);
    send_word(16'h1111);
    send_word(16'h2222);
    chk("post_reset_got_full", 32'(GOT_FULL_MSG), 32'd1);
    pop_hdr_chk();
    repeat (2) rd_chk();
    chk("post_reset_ovf", 32'(RX_OVF), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
